midi_note_tx: RTL and testbench



---
 rtl/midi_note_tx_if.sv | 28 ++
 rtl/midi_note_tx.sv | 195 +++++++++++++++++++
 tb/tb_midi_note_tx.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/midi_note_tx_if.sv
// midi_note_tx_if
//   Bundles the key inputs and the MIDI OUT side of midi_note_tx.
//   The master side (controller/testbench) drives the key levels; the slave
//   side (the transmitter) drives the serial line and the busy flag.
//
//   Signals:
//     keys     [N_KEYS-1:0]  asynchronous key levels, 1 = pressed
//     midi_tx                MIDI serial output, idle 1
//     busy                   high while a message is being shifted out
interface midi_note_tx_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] keys;
    logic              midi_tx;
    logic              busy;

    modport master (
        output keys,
        input  midi_tx,
        input  busy
    );

    modport slave (
        input  keys,
        output midi_tx,
        output busy
    );
endinterface

// File: rtl/midi_note_tx.sv
// midi_note_tx
//   Watches N_KEYS key inputs and sends a MIDI Note On for every press and a
//   Note Off for every release on a 31250 baud 8N1 MIDI OUT line (idle high).
//   Keys that change while a message is going out are served afterwards,
//   lowest index first; a press and release that both happen before service
//   cancel out and send nothing.
//
//   Parameters:
//     BAUD_DIV   clk cycles per MIDI bit (>= 2)
//     N_KEYS     number of key inputs (1..16)
//     BASE_NOTE  note number of key 0; key k sends BASE_NOTE+k
//     CHANNEL    MIDI channel nibble (0..15)
//     VELOCITY   Note On velocity (1..127)
//
//   Ports:
//     clk        system clock
//     rst        asynchronous active-high reset
//     bus        midi_note_tx_if.slave: keys in, midi_tx / busy out
//
//   Optional feature: define MIDI_RUNNING_STATUS_EN to send Note Off as
//   Note On with velocity 0 and to drop the status byte whenever it equals
//   the last status byte sent (2-byte messages).
module midi_note_tx #(
    parameter int BAUD_DIV  = 3200,
    parameter int N_KEYS    = 4,
    parameter int BASE_NOTE = 60,
    parameter int CHANNEL   = 0,
    parameter int VELOCITY  = 100
) (
    input  logic          clk,
    input  logic          rst,
    midi_note_tx_if.slave bus
);
    localparam int            TW       = $clog2(BAUD_DIV);
    localparam logic [TW-1:0] BIT_LAST = TW'(BAUD_DIV - 1);
    localparam logic [7:0]    NOTE_ON  = 8'h90 | 8'(CHANNEL);
    localparam logic [7:0]    NOTE_OFF = 8'h80 | 8'(CHANNEL);
    localparam logic [7:0]    BASE_B   = 8'(BASE_NOTE);
    localparam logic [7:0]    VEL_B    = 8'(VELOCITY);
`ifdef MIDI_RUNNING_STATUS_EN
    localparam logic [7:0]    OFF_VEL  = 8'h00;
`else
    localparam logic [7:0]    OFF_VEL  = 8'h40;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state;
    logic [N_KEYS-1:0] key_meta;
    logic [N_KEYS-1:0] key_s;
    logic [N_KEYS-1:0] sent_state;
    logic [N_KEYS-1:0] pending;
    logic [TW-1:0]     bit_timer;
    logic [2:0]        bit_idx;
    logic [1:0]        byte_idx;
    logic              ev_on;
    logic [3:0]        ev_key;
    logic              pick_valid;
    logic              pick_level;
    logic [3:0]        pick_idx;
    logic [7:0]        status_byte;
    logic [7:0]        cur_byte;
    logic              out_bit;
    logic              bit_end;
`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0]        last_status;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_meta <= '0;
            key_s    <= '0;
        end else begin
            key_meta <= bus.keys;
            key_s    <= key_meta;
        end
    end

    assign pending = key_s ^ sent_state;
    assign bit_end = (bit_timer == BIT_LAST);

    // Scan downwards so the last hit, i.e. the lowest pending index, wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_level = 1'b0;
        pick_idx   = 4'd0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                pick_valid = 1'b1;
                pick_level = key_s[i];
                pick_idx   = 4'(i);
            end
        end
    end

`ifdef MIDI_RUNNING_STATUS_EN
    assign status_byte = NOTE_ON;
`else
    assign status_byte = ev_on ? NOTE_ON : NOTE_OFF;
`endif

    always_comb begin
        case (byte_idx)
            2'd0:    cur_byte = status_byte;
            2'd1:    cur_byte = BASE_B + {4'd0, ev_key};
            default: cur_byte = ev_on ? VEL_B : OFF_VEL;
        endcase
    end

    always_comb begin
        case (state)
            START:   out_bit = 1'b0;
            DATA:    out_bit = cur_byte[bit_idx];
            default: out_bit = 1'b1;
        endcase
    end

    // midi_tx and busy are registered copies of the current state's line
    // value, so they trail the state by one cycle: the start bit appears the
    // edge after IDLE picks an event, and every bit still lasts BAUD_DIV.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sent_state  <= '0;
            bit_timer   <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
            ev_on       <= 1'b0;
            ev_key      <= '0;
            bus.midi_tx <= 1'b1;
            bus.busy    <= 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
            last_status <= 8'h00;
`endif
        end else begin
            bus.midi_tx <= out_bit;
            bus.busy    <= (state != IDLE);
            case (state)
                IDLE: begin
                    bit_timer <= '0;
                    if (pick_valid) begin
                        ev_on  <= pick_level;
                        ev_key <= pick_idx;
                        for (int i = 0; i < N_KEYS; i++) begin
                            if (4'(i) == pick_idx) sent_state[i] <= key_s[i];
                        end
`ifdef MIDI_RUNNING_STATUS_EN
                        if (last_status == NOTE_ON) begin
                            byte_idx <= 2'd1;
                        end else begin
                            byte_idx    <= 2'd0;
                            last_status <= NOTE_ON;
                        end
`else
                        byte_idx <= 2'd0;
`endif
                        state <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_timer <= '0;
                        bit_idx   <= '0;
                        state     <= DATA;
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        bit_timer <= '0;
                        if (bit_idx == 3'd7) state <= STOP;
                        else bit_idx <= bit_idx + 1'b1;
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        bit_timer <= '0;
                        if (byte_idx == 2'd2) begin
                            state <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                            state    <= START;
                        end
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_midi_note_tx.sv
// tb_midi_note_tx
//   Directed bench for midi_note_tx (BAUD_DIV=4, N_KEYS=4, BASE_NOTE=60,
//   CHANNEL=2, VELOCITY=100). Stimulus pushes the expected MIDI bytes and
//   busy lengths into queues; a UART monitor and a busy monitor pop and
//   compare as the DUT produces them. Honours MIDI_RUNNING_STATUS_EN.
module tb_midi_note_tx;
    localparam int B = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passes = 0;

    logic [7:0] exp_bytes[$];
    int         exp_busy[$];

    midi_note_tx_if #(.N_KEYS(4)) bus ();

    midi_note_tx #(
        .BAUD_DIV (B),
        .N_KEYS   (4),
        .BASE_NOTE(60),
        .CHANNEL  (2),
        .VELOCITY (100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic [3:0] k);
        @(negedge clk);
        bus.keys = k;
    endtask

    task automatic pushExp3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        exp_bytes.push_back(a);
        exp_bytes.push_back(b);
        exp_bytes.push_back(c);
        exp_busy.push_back(30 * B);
    endtask

    task automatic pushExp2(input logic [7:0] b, input logic [7:0] c);
        exp_bytes.push_back(b);
        exp_bytes.push_back(c);
        exp_busy.push_back(20 * B);
    endtask

    task automatic waitBusyLevel(input logic level, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy !== level && n < budget);
        if (bus.busy !== level) checkOutput("busy_wait_timeout", {31'd0, bus.busy}, {31'd0, level});
    endtask

    task automatic waitIdle();
        int streak = 0;
        int n = 0;
        while (streak < 12 && n < 3000) begin
            @(negedge clk);
            n++;
            if (!bus.busy && bus.midi_tx) streak++;
            else streak = 0;
        end
        if (streak < 12) checkOutput("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    // UART monitor: decodes one 8N1 frame per start bit, sampling mid-bit.
    logic [7:0] mon_byte;
    int         mon_cnt;
    bit         mon_active = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (bus.midi_tx === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                mon_byte   = 8'h00;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == B / 2) checkOutput("start_bit", {31'd0, bus.midi_tx}, 32'd0);
            if (mon_cnt > B && mon_cnt < 9 * B && (mon_cnt % B) == B / 2)
                mon_byte[mon_cnt / B - 1] = bus.midi_tx;
            if (mon_cnt == 9 * B + B / 2) begin
                checkOutput("stop_bit", {31'd0, bus.midi_tx}, 32'd1);
                if (exp_bytes.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_byte: got 0x%02h, want no byte", mon_byte);
                end else begin
                    checkOutput("midi_byte", {24'd0, mon_byte}, {24'd0, exp_bytes.pop_front()});
                end
                mon_active = 1'b0;
            end
        end
    end

    // Busy monitor: length of every busy-high run against the expected queue.
    int busy_run = 0;
    always @(negedge clk) begin
        if (rst) begin
            busy_run = 0;
        end else if (bus.busy === 1'b1) begin
            busy_run++;
        end else if (busy_run != 0) begin
            if (exp_busy.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_busy: got %0d cycles, want none", busy_run);
            end else begin
                checkOutput("busy_len", busy_run, exp_busy.pop_front());
            end
            busy_run = 0;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int gap;
        int activity;
        rst      = 1'b1;
        bus.keys = 4'b0000;
        repeat (3) @(negedge clk);
        checkOutput("reset_midi_tx", {31'd0, bus.midi_tx}, 32'd1);
        checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);

        // Press key0: full Note On, start bit three edges after sampling.
        pushExp3(8'h92, 8'h3C, 8'h64);
        applyStimulus(4'b0001);
        repeat (3) @(posedge clk);
        #1 checkOutput("pre_start_line", {31'd0, bus.midi_tx}, 32'd1);
        @(posedge clk);
        #1 checkOutput("start_fall", {31'd0, bus.midi_tx}, 32'd0);
        checkOutput("busy_rise", {31'd0, bus.busy}, 32'd1);
        waitIdle();

        // Release key0.
`ifdef MIDI_RUNNING_STATUS_EN
        pushExp2(8'h3C, 8'h00);
`else
        pushExp3(8'h82, 8'h3C, 8'h40);
`endif
        applyStimulus(4'b0000);
        waitIdle();

        // Fresh reset so the simultaneous-press message carries status.
        pulseReset();
        repeat (3) @(negedge clk);

        // key1 and key3 on the same edge: ascending order, 1 idle cycle apart.
        pushExp3(8'h92, 8'h3D, 8'h64);
`ifdef MIDI_RUNNING_STATUS_EN
        pushExp2(8'h3F, 8'h64);
`else
        pushExp3(8'h92, 8'h3F, 8'h64);
`endif
        applyStimulus(4'b1010);
        waitBusyLevel(1'b1, 50);
        waitBusyLevel(1'b0, 400);
        gap = 1;
        @(negedge clk);
        while (bus.busy !== 1'b1 && gap < 20) begin
            gap++;
            @(negedge clk);
        end
        checkOutput("inter_message_gap", gap, 1);
        waitIdle();

        // Release key1 and key3.
`ifdef MIDI_RUNNING_STATUS_EN
        pushExp2(8'h3D, 8'h00);
        pushExp2(8'h3F, 8'h00);
`else
        pushExp3(8'h82, 8'h3D, 8'h40);
        pushExp3(8'h82, 8'h3F, 8'h40);
`endif
        applyStimulus(4'b0000);
        waitIdle();

        // Press key0, then tap key2 while busy: the tap coalesces away.
`ifdef MIDI_RUNNING_STATUS_EN
        pushExp2(8'h3C, 8'h64);
`else
        pushExp3(8'h92, 8'h3C, 8'h64);
`endif
        applyStimulus(4'b0001);
        waitBusyLevel(1'b1, 50);
        repeat (20) @(negedge clk);
        applyStimulus(4'b0101);
        repeat (6) @(negedge clk);
        applyStimulus(4'b0001);
        waitIdle();
        activity = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.midi_tx !== 1'b1) activity++;
        end
        checkOutput("quiet_after_coalesce", activity, 0);

        // Release key0.
`ifdef MIDI_RUNNING_STATUS_EN
        pushExp2(8'h3C, 8'h00);
`else
        pushExp3(8'h82, 8'h3C, 8'h40);
`endif
        applyStimulus(4'b0000);
        waitIdle();

        // Press key0 and reset in the middle of a data bit.
`ifdef MIDI_RUNNING_STATUS_EN
        pushExp2(8'h3C, 8'h64);
`else
        pushExp3(8'h92, 8'h3C, 8'h64);
`endif
        applyStimulus(4'b0001);
        waitBusyLevel(1'b1, 50);
        repeat (14) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("async_reset_midi_tx", {31'd0, bus.midi_tx}, 32'd1);
        checkOutput("async_reset_busy", {31'd0, bus.busy}, 32'd0);
        exp_bytes.delete();
        exp_busy.delete();
        repeat (3) @(negedge clk);
        pushExp3(8'h92, 8'h3C, 8'h64);
        #1 rst = 1'b0;
        waitIdle();

        checkOutput("leftover_bytes", exp_bytes.size(), 0);
        checkOutput("leftover_busy", exp_busy.size(), 0);
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
